// File: rtl/seq_divider_mxn_if.sv
// Operand/result bundle for the sequential MxN divider.
// The master side issues start with its operands; the slave side returns the result and status.
interface seq_divider_mxn_if #(
  parameter int M = 8,
  parameter int N = 4
);
  logic         start;
  logic         P;
  logic [M-1:0] a;
  logic [N-1:0] b;
  logic [M-1:0] q;
  logic [N-1:0] r;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  modport master (
    output start, P, a, b,
    input  q, r, busy, done, div_by_zero
  );

  modport slave (
    input  start, P, a, b,
    output q, r, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_divider_mxn.sv
// Iterative restoring divider: one quotient bit per clock, unsigned or two's-complement
// operands, truncating division with a start/done handshake.
module seq_divider_mxn #(
  parameter int M = 8,
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst,
  seq_divider_mxn_if.slave   bus
);
  localparam int CW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [M-1:0]  dvd_reg;      // |a| shifts out of the top while quotient bits shift in below
  logic [N-1:0]  abs_b_reg;
  logic [N:0]    rem_reg;
  logic          sign_a_reg, sign_b_reg;
  logic [M-1:0]  q_reg;
  logic [N-1:0]  r_reg;
  logic          dz_reg;

  logic          b_zero;
  logic [M-1:0]  abs_a;
  logic [N-1:0]  abs_b;
  logic [N:0]    shifted, diff;
  logic          fits;
  logic          busy, done;

  always_comb begin
    b_zero  = (bus.b == '0);
    abs_a   = (bus.P & bus.a[M-1]) ? -bus.a : bus.a;
    abs_b   = (bus.P & bus.b[N-1]) ? -bus.b : bus.b;
    shifted = {rem_reg[N-1:0], dvd_reg[M-1]};
    fits    = (shifted >= {1'b0, abs_b_reg});
    diff    = shifted - {1'b0, abs_b_reg};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = b_zero ? DONE : CALC;
      CALC:    if (cnt_reg == CW'(M - 1)) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      CALC, FIX: busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      dvd_reg    <= '0;
      abs_b_reg  <= '0;
      rem_reg    <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      q_reg      <= '0;
      r_reg      <= '0;
      dz_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (bus.start) begin
          sign_a_reg <= bus.P & bus.a[M-1];
          sign_b_reg <= bus.P & bus.b[N-1];
          dvd_reg    <= abs_a;
          abs_b_reg  <= abs_b;
          rem_reg    <= '0;
          cnt_reg    <= '0;
          dz_reg     <= b_zero;
          // Divide-by-zero skips straight to DONE, so its result must be loaded on entry.
          if (b_zero) begin
            q_reg <= '1;
            r_reg <= bus.a[N-1:0];
          end
        end
        CALC: begin
          rem_reg <= fits ? diff : shifted;
          dvd_reg <= {dvd_reg[M-2:0], fits};
          cnt_reg <= cnt_reg + 1'b1;
        end
        FIX: begin
          q_reg <= (sign_a_reg ^ sign_b_reg) ? -dvd_reg : dvd_reg;
          r_reg <= sign_a_reg ? -rem_reg[N-1:0] : rem_reg[N-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.q           = q_reg;
  assign bus.r           = r_reg;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.div_by_zero = dz_reg;
endmodule

// File: tb/tb_seq_divider_mxn.sv
// Directed self-checking bench for seq_divider_mxn (M=8, N=4): vector table plus
// hand-written sequences for start-while-busy, back-to-back and mid-operation reset.
module tb_seq_divider_mxn;
  localparam int M = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_divider_mxn_if #(.M(M), .N(N)) bus ();

  seq_divider_mxn #(.M(M), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic         p;
    logic [M-1:0] a;
    logic [N-1:0] b;
    logic [M-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Leaves the bench #1 after the edge that sampled start.
  task automatic do_start(input logic p, input logic [M-1:0] a, input logic [N-1:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.P     = p;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Counts further edges until done is seen; gives up after 50.
  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int seen;

    vecs[0]  = '{1'b0, 8'd200, 4'd7, 8'd28,  4'd4, 1'b0, 9};
    vecs[1]  = '{1'b1, 8'h9C,  4'h7, 8'hF2,  4'hE, 1'b0, 9};
    vecs[2]  = '{1'b1, 8'h64,  4'h9, 8'hF2,  4'h2, 1'b0, 9};
    vecs[3]  = '{1'b0, 8'h55,  4'h0, 8'hFF,  4'h5, 1'b1, 0};
    vecs[4]  = '{1'b1, 8'h55,  4'h0, 8'hFF,  4'h5, 1'b1, 0};
    vecs[5]  = '{1'b0, 8'd100, 4'd3, 8'd33,  4'd1, 1'b0, 9};
    vecs[6]  = '{1'b1, 8'h80,  4'hF, 8'h80,  4'h0, 1'b0, 9};
    vecs[7]  = '{1'b1, 8'h80,  4'h8, 8'h10,  4'h0, 1'b0, 9};
    vecs[8]  = '{1'b0, 8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 9};
    vecs[9]  = '{1'b1, 8'hF9,  4'hE, 8'h03,  4'hF, 1'b0, 9};
    vecs[10] = '{1'b0, 8'd15,  4'd4, 8'd3,   4'd3, 1'b0, 9};

    bus.start = 1'b0;
    bus.P     = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_q",    32'(bus.q), 32'h0);
    chk("reset_r",    32'(bus.r), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_done", 32'(bus.done), 32'h0);
    chk("reset_dz",   32'(bus.div_by_zero), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_start(vecs[i].p, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_busy_after_start", i), 32'(bus.busy), 32'h1);
      wait_done(n);
      chk($sformatf("v%0d_latency", i), 32'(n), 32'(vecs[i].lat));
      chk($sformatf("v%0d_q", i), 32'(bus.q), 32'(vecs[i].q));
      chk($sformatf("v%0d_r", i), 32'(bus.r), 32'(vecs[i].r));
      chk($sformatf("v%0d_dz", i), 32'(bus.div_by_zero), 32'(vecs[i].dz));
      $display("vec %0d: P=%0d a=%h b=%h -> q=%h r=%h dz=%0d lat=%0d",
               i, vecs[i].p, vecs[i].a, vecs[i].b, bus.q, bus.r, bus.div_by_zero, n);
    end

    // Done is a single pulse and results hold afterwards.
    @(posedge clk); #1;
    chk("post_done_low", 32'(bus.done), 32'h0);
    chk("post_busy_low", 32'(bus.busy), 32'h0);
    chk("post_q_hold",   32'(bus.q), 32'd3);
    chk("post_r_hold",   32'(bus.r), 32'd3);
    $display("hold: q=%h r=%h done=%0d busy=%0d", bus.q, bus.r, bus.done, bus.busy);

    // Start while busy is ignored; a start right after done is taken.
    do_start(1'b0, 8'd200, 4'd7);
    repeat (3) begin @(posedge clk); #1; end
    bus.start = 1'b1;
    bus.a     = 8'd9;
    bus.b     = 4'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(n);
    chk("busy_start_latency", 32'(n), 32'd5);
    chk("busy_start_q", 32'(bus.q), 32'd28);
    chk("busy_start_r", 32'(bus.r), 32'd4);
    $display("start-while-busy: q=%0d r=%0d", bus.q, bus.r);
    do_start(1'b0, 8'd9, 4'd3);
    wait_done(n);
    chk("b2b_latency", 32'(n), 32'd9);
    chk("b2b_q", 32'(bus.q), 32'd3);
    chk("b2b_r", 32'(bus.r), 32'd0);
    $display("back-to-back: q=%0d r=%0d", bus.q, bus.r);

    // Reset in the 4th CALC cycle clears outputs at once and suppresses done.
    do_start(1'b0, 8'd200, 4'd7);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midrst_q",    32'(bus.q), 32'h0);
    chk("midrst_r",    32'(bus.r), 32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    chk("midrst_done", 32'(bus.done), 32'h0);
    chk("midrst_dz",   32'(bus.div_by_zero), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    $display("mid-op reset: q=%h r=%h busy=%0d, stray activity cycles=%0d", bus.q, bus.r, bus.busy, seen);
    do_start(1'b0, 8'd15, 4'd4);
    wait_done(n);
    chk("after_rst_latency", 32'(n), 32'd9);
    chk("after_rst_q", 32'(bus.q), 32'd3);
    chk("after_rst_r", 32'(bus.r), 32'd3);
    $display("after reset: q=%0d r=%0d", bus.q, bus.r);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
